// File: rtl/hyperbus_burst_fifo.sv
// Single-clock command/burst bridge. It queues user commands and data, and runs each
// command as one multi-beat Hyperbus request with head-of-line blocking.
module hyperbus_burst_fifo_sync #(
    parameter int W  = 8,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);
    localparam int DEPTH = 1 << AW;

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wptr, rptr;

    // The extra pointer MSB makes a full FIFO read as level == DEPTH.
    assign level = wptr - rptr;
    assign full  = level[AW];
    assign empty = (level == '0);
    assign dout  = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push && !full) wptr <= wptr + (AW+1)'(1);
            if (pop && !empty) rptr <= rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) mem[wptr[AW-1:0]] <= din;
    end
endmodule

module hyperbus_burst_fifo #(
    parameter int FIFO_DATA_WIDTH = 32,
    parameter int HBUS_DATA_WIDTH = 16,
    parameter int HBUS_ADDR_WIDTH = 32,
    parameter int DATA_ASIZE      = 3,
    parameter int CMD_ASIZE       = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_we,
    input  logic [HBUS_ADDR_WIDTH-1:0] cmd_adr,
    input  logic [DATA_ASIZE-1:0]      cmd_len,
    input  logic [FIFO_DATA_WIDTH-1:0] wr_dat,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    output logic [FIFO_DATA_WIDTH-1:0] rd_dat,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [HBUS_ADDR_WIDTH-1:0] hbus_adr_o,
    output logic [HBUS_DATA_WIDTH-1:0] hbus_dat_o,
    input  logic [HBUS_DATA_WIDTH-1:0] hbus_dat_i,
    output logic                       hbus_rrq,
    output logic                       hbus_wrq,
    input  logic                       hbus_ready,
    input  logic                       hbus_valid,
    input  logic                       hbus_busy,
    output logic [CMD_ASIZE:0]         cmd_level
);
    localparam int CYCLES = FIFO_DATA_WIDTH / HBUS_DATA_WIDTH;
    localparam int BW     = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam int CW     = 1 + HBUS_ADDR_WIDTH + DATA_ASIZE;
    localparam logic [DATA_ASIZE:0] DDEPTH = (DATA_ASIZE+1)'(1 << DATA_ASIZE);

    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

    state_t                       state;
    logic                         arm, start, cond, rx_pend;
    logic [FIFO_DATA_WIDTH-1:0]   tx_sr, rx_sr, tx_dout;
    logic [DATA_ASIZE-1:0]        word_cnt;
    logic [BW-1:0]                beat_cnt;
    logic [CW-1:0]                cmd_dout;
    logic                         cmd_full, cmd_empty, tx_full, tx_empty, tx_pop, rx_full, rx_empty;
    logic [DATA_ASIZE:0]          tx_level, rx_level, rx_free, need;
    logic                         head_we;
    logic [HBUS_ADDR_WIDTH-1:0]   head_adr;
    logic [DATA_ASIZE-1:0]        head_len;

    hyperbus_burst_fifo_sync #(.W(CW), .AW(CMD_ASIZE)) u_cmd (
        .clk(clk), .rst_n(rst_n), .push(cmd_valid), .din({cmd_we, cmd_adr, cmd_len}),
        .pop(start), .dout(cmd_dout), .full(cmd_full), .empty(cmd_empty), .level(cmd_level));

    hyperbus_burst_fifo_sync #(.W(FIFO_DATA_WIDTH), .AW(DATA_ASIZE)) u_tx (
        .clk(clk), .rst_n(rst_n), .push(wr_valid), .din(wr_dat),
        .pop(tx_pop), .dout(tx_dout), .full(tx_full), .empty(tx_empty), .level(tx_level));

    hyperbus_burst_fifo_sync #(.W(FIFO_DATA_WIDTH), .AW(DATA_ASIZE)) u_rx (
        .clk(clk), .rst_n(rst_n), .push(rx_pend && !rx_full), .din(rx_sr),
        .pop(rd_ready), .dout(rd_dat), .full(rx_full), .empty(rx_empty), .level(rx_level));

    assign {head_we, head_adr, head_len} = cmd_dout;
    assign cmd_ready  = !cmd_full;
    assign wr_ready   = !tx_full;
    assign rd_valid   = !rx_empty;
    assign hbus_dat_o = tx_sr[FIFO_DATA_WIDTH-1 -: HBUS_DATA_WIDTH];

    assign need    = {1'b0, head_len} + (DATA_ASIZE+1)'(1);
    assign rx_free = DDEPTH - rx_level;
    assign cond    = (state == IDLE) && !cmd_empty && !hbus_busy &&
                     (head_we ? (tx_level >= need) : (rx_free >= need));
    // A start needs the condition on two consecutive cycles; this sets the
    // N+2 request latency and guarantees an idle cycle between bursts.
    assign start   = cond && arm;
    assign tx_pop  = !tx_empty && ((start && head_we) ||
                     (state == WRITE && hbus_ready && beat_cnt == '0 && word_cnt != '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            arm        <= 1'b0;
            rx_pend    <= 1'b0;
            hbus_adr_o <= '0;
            hbus_wrq   <= 1'b0;
            hbus_rrq   <= 1'b0;
            tx_sr      <= '0;
            rx_sr      <= '0;
            word_cnt   <= '0;
            beat_cnt   <= '0;
        end else begin
            arm     <= cond && !arm;
            rx_pend <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    hbus_adr_o <= head_adr;
                    word_cnt   <= head_len;
                    beat_cnt   <= BW'(CYCLES-1);
                    if (head_we) begin
                        tx_sr    <= tx_dout;
                        hbus_wrq <= 1'b1;
                        state    <= WRITE;
                    end else begin
                        rx_sr    <= '0;
                        hbus_rrq <= 1'b1;
                        state    <= READ;
                    end
                end
                WRITE: if (hbus_ready) begin
                    if (beat_cnt != '0) begin
                        tx_sr    <= tx_sr << HBUS_DATA_WIDTH;
                        beat_cnt <= beat_cnt - BW'(1);
                    end else if (word_cnt == '0) begin
                        hbus_wrq <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        tx_sr    <= tx_dout;
                        word_cnt <= word_cnt - DATA_ASIZE'(1);
                        beat_cnt <= BW'(CYCLES-1);
                    end
                end
                READ: if (hbus_valid) begin
                    rx_sr <= (rx_sr << HBUS_DATA_WIDTH) | FIFO_DATA_WIDTH'(hbus_dat_i);
                    if (beat_cnt != '0) begin
                        beat_cnt <= beat_cnt - BW'(1);
                    end else begin
                        // Completed word is pushed on the following edge.
                        rx_pend <= 1'b1;
                        if (word_cnt == '0) begin
                            hbus_rrq <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            word_cnt <= word_cnt - DATA_ASIZE'(1);
                            beat_cnt <= BW'(CYCLES-1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hyperbus_burst_fifo.sv
// Directed bench for hyperbus_burst_fifo: reset values, write/read bursts,
// head-of-line blocking, full flags, mixed traffic with busy, and mid-burst reset.
module tb_hyperbus_burst_fifo;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
    logic [31:0] cmd_adr = '0;
    logic [2:0]  cmd_len = '0;
    logic [31:0] wr_dat = '0, rd_dat;
    logic        wr_valid = 1'b0, wr_ready, rd_valid, rd_ready = 1'b0;
    logic [31:0] hbus_adr_o;
    logic [15:0] hbus_dat_o, hbus_dat_i = '0;
    logic        hbus_rrq, hbus_wrq, hbus_ready = 1'b0, hbus_valid = 1'b0, hbus_busy = 1'b0;
    logic [2:0]  cmd_level;

    int errors = 0;
    int checks = 0;

    logic [15:0] w3_dat [4] = '{16'h2222, 16'h3333, 16'h4444, 16'h4444};
    logic        w3_wrq [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [15:0] mix_beats [2] = '{16'hA0A0, 16'hB0B0};
    logic [31:0] rec_adr [3];
    logic [15:0] rec_dat [3];
    logic        rec_wr  [3];
    logic [1:0]  prev_req, cur_req;
    logic        prev_busy;
    int          nrec, busy_cnt, bi;

    hyperbus_burst_fifo dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_len(cmd_len),
        .wr_dat(wr_dat), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_dat(rd_dat), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .hbus_adr_o(hbus_adr_o), .hbus_dat_o(hbus_dat_o), .hbus_dat_i(hbus_dat_i),
        .hbus_rrq(hbus_rrq), .hbus_wrq(hbus_wrq), .hbus_ready(hbus_ready),
        .hbus_valid(hbus_valid), .hbus_busy(hbus_busy), .cmd_level(cmd_level));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] d);
        wr_valid = 1'b1;
        wr_dat   = d;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic push_cmd(input logic we, input logic [31:0] adr, input logic [2:0] len);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_len   = len;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_req(input string tag, input logic wr);
        int n = 0;
        while (((wr ? hbus_wrq : hbus_rrq) !== 1'b1) && n < 40) begin
            tick();
            n++;
        end
        chk(tag, wr ? hbus_wrq : hbus_rrq, 1'b1);
    endtask

    initial begin
        // reset state
        tick(); tick();
        chk("rst_rrq", hbus_rrq, 0);
        chk("rst_wrq", hbus_wrq, 0);
        chk("rst_adr", hbus_adr_o, 0);
        chk("rst_dat", hbus_dat_o, 0);
        chk("rst_level", cmd_level, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_rd_valid", rd_valid, 0);
        rst_n = 1'b1;
        tick();

        // single write, request at N+2
        push_word(32'hDEADBEEF);
        push_cmd(1'b1, 32'h100, 3'd0);
        chk("w1_n0_wrq", hbus_wrq, 0);
        chk("w1_level", cmd_level, 1);
        tick();
        chk("w1_n1_wrq", hbus_wrq, 0);
        tick();
        chk("w1_n2_wrq", hbus_wrq, 1);
        chk("w1_adr", hbus_adr_o, 32'h100);
        chk("w1_beat0", hbus_dat_o, 16'hDEAD);
        chk("w1_level0", cmd_level, 0);
        hbus_ready = 1'b1;
        tick();
        chk("w1_beat1", hbus_dat_o, 16'hBEEF);
        chk("w1_wrq_mid", hbus_wrq, 1);
        tick();
        chk("w1_wrq_fall", hbus_wrq, 0);
        chk("w1_dat_hold", hbus_dat_o, 16'hBEEF);
        hbus_ready = 1'b0;

        // read burst len=3
        push_cmd(1'b0, 32'h200, 3'd3);
        tick(); tick();
        chk("r1_rrq", hbus_rrq, 1);
        chk("r1_adr", hbus_adr_o, 32'h200);
        for (int k = 1; k <= 8; k++) begin
            hbus_valid = 1'b1;
            hbus_dat_i = 16'(k);
            chk("r1_rrq_hold", hbus_rrq, 1);
            tick();
        end
        hbus_valid = 1'b0;
        chk("r1_rrq_drop", hbus_rrq, 0);
        tick();
        rd_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            chk("r1_rd_valid", rd_valid, 1);
            chk("r1_rd_dat", rd_dat, {16'(2*j+1), 16'(2*j+2)});
            tick();
        end
        rd_ready = 1'b0;
        chk("r1_rx_empty", rd_valid, 0);

        // write command queued before its data
        push_cmd(1'b1, 32'h300, 3'd1);
        repeat (3) tick();
        chk("w3_nodata", hbus_wrq, 0);
        push_word(32'h11112222);
        chk("w3_oneword", hbus_wrq, 0);
        push_word(32'h33334444);
        chk("w3_m0", hbus_wrq, 0);
        tick();
        chk("w3_m1", hbus_wrq, 0);
        tick();
        chk("w3_m2", hbus_wrq, 1);
        chk("w3_beat0", hbus_dat_o, 16'h1111);
        hbus_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("w3_beat", hbus_dat_o, w3_dat[i]);
            chk("w3_wrq", hbus_wrq, w3_wrq[i]);
        end
        hbus_ready = 1'b0;

        // full conditions
        hbus_busy = 1'b1;
        for (int i = 0; i < 4; i++) push_cmd(1'b1, 32'h400 + 32'(i), 3'd0);
        chk("full_cmd_ready", cmd_ready, 0);
        chk("full_cmd_level", cmd_level, 4);
        push_cmd(1'b1, 32'h4FF, 3'd0);
        chk("full_cmd_ignored", cmd_level, 4);
        chk("full_busy_wrq", hbus_wrq, 0);
        for (int i = 0; i < 8; i++) push_word({16'(16'hA0 + i), 16'(16'hB0 + i)});
        chk("full_wr_ready", wr_ready, 0);
        hbus_busy = 1'b0;
        hbus_ready = 1'b1;
        repeat (30) tick();
        chk("full_drained_level", cmd_level, 0);
        chk("full_drained_wrq", hbus_wrq, 0);
        chk("full_wr_ready_back", wr_ready, 1);
        push_cmd(1'b1, 32'h480, 3'd3);
        wait_req("w4_start", 1'b1);
        chk("w4_first_beat", hbus_dat_o, 16'h00A4);
        repeat (12) tick();
        chk("w4_done", hbus_wrq, 0);
        hbus_ready = 1'b0;

        // read len=7 blocked while RX holds one word
        push_cmd(1'b0, 32'h610, 3'd0);
        wait_req("r2_start", 1'b0);
        hbus_valid = 1'b1;
        hbus_dat_i = 16'hAAAA;
        tick();
        hbus_dat_i = 16'hBBBB;
        tick();
        hbus_valid = 1'b0;
        tick();
        chk("r2_rd_valid", rd_valid, 1);
        push_cmd(1'b0, 32'h620, 3'd7);
        repeat (6) tick();
        chk("r7_blocked", hbus_rrq, 0);
        chk("r7_level", cmd_level, 1);
        rd_ready = 1'b1;
        chk("r2_rd_dat", rd_dat, 32'hAAAABBBB);
        tick();
        rd_ready = 1'b0;
        chk("r7_p0", hbus_rrq, 0);
        tick();
        chk("r7_p1", hbus_rrq, 0);
        tick();
        chk("r7_p2", hbus_rrq, 1);
        chk("r7_adr", hbus_adr_o, 32'h620);
        for (int k = 0; k < 16; k++) begin
            hbus_valid = 1'b1;
            hbus_dat_i = 16'h0100 + 16'(k);
            tick();
        end
        hbus_valid = 1'b0;
        chk("r7_rrq_drop", hbus_rrq, 0);
        tick();
        rd_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            chk("r7_rd_dat", rd_dat, {16'h0100 + 16'(2*j), 16'h0100 + 16'(2*j+1)});
            tick();
        end
        rd_ready = 1'b0;
        chk("r7_rx_empty", rd_valid, 0);

        // back-to-back mixed traffic with busy after each burst
        hbus_busy = 1'b1;
        push_word(32'hCAFEF00D);
        push_word(32'h12345678);
        push_cmd(1'b1, 32'h500, 3'd0);
        push_cmd(1'b0, 32'h600, 3'd0);
        push_cmd(1'b1, 32'h700, 3'd0);
        hbus_ready = 1'b1;
        prev_req = 2'b00;
        prev_busy = 1'b1;
        busy_cnt = 4;
        nrec = 0;
        bi = 0;
        for (int c = 0; c < 60; c++) begin
            cur_req = {hbus_wrq, hbus_rrq};
            if (cur_req != prev_req && cur_req != 2'b00)
                chk("mix_idle_gap", prev_req, 2'b00);
            if (prev_req == 2'b00 && cur_req != 2'b00) begin
                chk("mix_busy_clear", prev_busy, 0);
                if (nrec < 3) begin
                    rec_adr[nrec] = hbus_adr_o;
                    rec_dat[nrec] = hbus_dat_o;
                    rec_wr[nrec]  = hbus_wrq;
                end
                nrec++;
            end
            if (prev_req != 2'b00 && cur_req == 2'b00) busy_cnt = 3;
            hbus_busy = (busy_cnt > 0);
            if (busy_cnt > 0) busy_cnt--;
            hbus_valid = hbus_rrq;
            hbus_dat_i = (bi < 2) ? mix_beats[bi] : 16'h0;
            if (hbus_rrq && bi < 2) bi++;
            prev_busy = hbus_busy;
            prev_req = cur_req;
            tick();
        end
        hbus_valid = 1'b0;
        hbus_ready = 1'b0;
        chk("mix_count", nrec, 3);
        chk("mix_kind0", rec_wr[0], 1);
        chk("mix_kind1", rec_wr[1], 0);
        chk("mix_kind2", rec_wr[2], 1);
        chk("mix_adr0", rec_adr[0], 32'h500);
        chk("mix_adr1", rec_adr[1], 32'h600);
        chk("mix_adr2", rec_adr[2], 32'h700);
        chk("mix_dat0", rec_dat[0], 16'hCAFE);
        chk("mix_dat2", rec_dat[2], 16'h1234);
        chk("mix_rd_valid", rd_valid, 1);
        chk("mix_rd_dat", rd_dat, 32'hA0A0B0B0);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;

        // reset mid-READ after 3 beats
        push_cmd(1'b0, 32'h800, 3'd3);
        wait_req("rr_start", 1'b0);
        for (int k = 1; k <= 3; k++) begin
            hbus_valid = 1'b1;
            hbus_dat_i = 16'(k);
            tick();
        end
        hbus_valid = 1'b0;
        push_cmd(1'b0, 32'h900, 3'd0);
        chk("rr_pre_level", cmd_level, 1);
        chk("rr_pre_rd_valid", rd_valid, 1);
        chk("rr_pre_rrq", hbus_rrq, 1);
        rst_n = 1'b0;
        #1;
        chk("rr_rrq", hbus_rrq, 0);
        chk("rr_rd_valid", rd_valid, 0);
        chk("rr_level", cmd_level, 0);
        chk("rr_adr", hbus_adr_o, 0);
        tick();
        rst_n = 1'b1;
        tick();
        push_word(32'h5A5AA5A5);
        push_cmd(1'b1, 32'hA00, 3'd0);
        wait_req("rr_w_start", 1'b1);
        chk("rr_w_adr", hbus_adr_o, 32'hA00);
        chk("rr_w_beat0", hbus_dat_o, 16'h5A5A);
        hbus_ready = 1'b1;
        tick();
        chk("rr_w_beat1", hbus_dat_o, 16'hA5A5);
        tick();
        chk("rr_w_done", hbus_wrq, 0);
        hbus_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/hyperbus_burst_fifo.md
Name: hyperbus_burst_fifo

Overview:
- Single-clock successor to the dual-clock Hyperbus FIFO bridge.
- Queues user read/write commands with a burst length and converts each command into one multi-word Hyperbus transaction on the native memory interface.
- Widths and all FIFO depths are parameterised; TX, RX and command buffers are synchronous FIFOs.
- Sits between a DMA/bus master and the Hyperbus controller in the same clock domain.

Parameters:
- FIFO_DATA_WIDTH, 32, user word width; must be an integer multiple of HBUS_DATA_WIDTH.
- HBUS_DATA_WIDTH, 16, Hyperbus beat width.
- HBUS_ADDR_WIDTH, 32, address width.
- DATA_ASIZE, 3, log2 depth of the TX and RX FIFOs (8 words); also the width of cmd_len.
- CMD_ASIZE, 2, log2 depth of the command FIFO (4 entries).

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous reset, active low.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command FIFO not full.
- cmd_we  in  1  1 = write, 0 = read.
- cmd_adr  in  HBUS_ADDR_WIDTH  start address.
- cmd_len  in  DATA_ASIZE  burst length in words, minus 1.
- wr_dat  in  FIFO_DATA_WIDTH  write data.
- wr_valid  in  1  write data offered.
- wr_ready  out  1  TX FIFO not full.
- rd_dat  out  FIFO_DATA_WIDTH  read data (first-word fall-through).
- rd_valid  out  1  RX FIFO not empty.
- rd_ready  in  1  consumer accepts rd_dat.
- hbus_adr_o  out  HBUS_ADDR_WIDTH  transaction address.
- hbus_dat_o  out  HBUS_DATA_WIDTH  write beat, MSB slice of the TX shift register.
- hbus_dat_i  in  HBUS_DATA_WIDTH  read beat.
- hbus_rrq  out  1  read request, held for the whole burst.
- hbus_wrq  out  1  write request, held for the whole burst.
- hbus_ready  in  1  controller consumes the current write beat.
- hbus_valid  in  1  read beat valid.
- hbus_busy  in  1  controller occupied; no new request may start.
- cmd_level  out  CMD_ASIZE+1  command FIFO occupancy.

Behaviour:
- Reset (async, rst_n=0):
  - All FIFOs empty; state IDLE.
  - hbus_rrq, hbus_wrq, hbus_adr_o, hbus_dat_o and cmd_level are 0.
  - cmd_ready and wr_ready are 1; rd_valid is 0.
  - Reset mid-burst aborts immediately and discards queued data.
- Beats per word: CYCLES = FIFO_DATA_WIDTH/HBUS_DATA_WIDTH. Beats per burst: (cmd_len+1)*CYCLES.
- Handshakes: transfers occur when valid&ready on cmd_*, wr_* and rd_*. A push and a pop on the same FIFO in the same cycle are both honoured and leave the occupancy unchanged.
- Write data is queued independently of commands, in command order.
- FSM states: IDLE, WRITE, READ.
- IDLE: waits for cmd FIFO non-empty and hbus_busy=0, plus a start condition:
  - Write start: TX occupancy >= cmd_len+1.
  - Read start: RX free space >= cmd_len+1.
  - If the start condition fails, wait and do not pop (head-of-line blocking).
  - On start, in one registered cycle:
    - Pop the command and latch hbus_adr_o.
    - Load the word counter = cmd_len and the beat counter = CYCLES-1.
    - Write: pop the first TX word into the shift register and set hbus_wrq=1.
    - Read: clear the RX shift register and set hbus_rrq=1.
- Latency: a command accepted at edge N with its start condition already met raises the request at edge N+2.
- WRITE:
  - Each cycle with hbus_ready=1: shift left by HBUS_DATA_WIDTH and decrement the beat counter.
  - At a word boundary (beat counter 0, more words left): load the next TX word, decrement the word counter, reload beats.
  - On the final beat, clear hbus_wrq in the same edge and return to IDLE.
  - hbus_ready with hbus_wrq=0 is ignored.
- READ:
  - Each hbus_valid beat is shifted in at the LSB (the first beat lands in the MSBs).
  - After CYCLES beats, push the word to the RX FIFO on the next edge.
  - On the final beat, clear hbus_rrq and return to IDLE.
  - RX overflow cannot occur, because of the start check.
- Idle behaviour: IDLE is re-entered for at least one cycle between bursts. hbus_dat_o holds its last value when idle.
- Overflow and underflow guards: a push to a full FIFO or a pop from an empty FIFO is ignored; the ready/valid outputs already prevent both.
- cmd_len = 2**DATA_ASIZE-1 is the maximum burst and is legal.
- FIFO pointers wrap modulo their depth; the extra MSB distinguishes full from empty.

Test Plan:
- Single write: cmd_we=1, adr=0x100, len=0, wr_dat=0xDEADBEEF → hbus_wrq rises at N+2; hbus_dat_o=0xDEAD then 0xBEEF on successive hbus_ready cycles; wrq falls with the second beat.
- Read burst: len=3, controller returns beats 0x0001..0x0008 → rd_dat sequence 0x00010002, 0x00030004, 0x00050006, 0x00070008; hbus_rrq high for exactly 8 valid beats.
- Write command queued before its data: cmd len=1 with TX empty → no hbus_wrq until the second word is pushed, then the request rises two edges later.
- Full conditions: 4 commands with hbus_busy=1 → cmd_ready=0, cmd_level=4; 8 words pushed → wr_ready=0; a read of len=7 with rd_ready=0 while RX is holding 1 word → does not start until RX is drained.
- Back-to-back mixed traffic: write, read and write commands queued → bursts execute in order, each separated by at least one IDLE cycle; hbus_busy=1 delays each start.
- Reset mid-READ after 3 beats → hbus_rrq=0 immediately, rd_valid=0, cmd_level=0; after release a new command completes normally.
